dfg_stream_sink: RTL

- Terminal consumer for the dataflow operator chain's ready/data output pair (R_OUT/D_OUT of the last operator, wired to R_IN/D_IN here).
- Captures each token into a FIFO and counts tokens against a host-programmed expected total.
- Drains tokens to the host side over a valid/ready handshake and signals completion.
- The operator protocol has no backpressure, so the block itself detects and flags overflow.

---
 rtl/dfg_pkg.sv | 24 ++
 rtl/dfg_sync_fifo.sv | 82 ++++++++
 rtl/dfg_stream_sink.sv | 128 ++++++++++++
 3 files changed

// File: rtl/dfg_pkg.sv
// Shared definitions for the dataflow operator chain and its stream sink.
//
// Contents:
//   DfgTokenW     default token data width, shared with the operators.
//   sink_state_e  stream sink run-state encoding.
//   ptr_w()       address width of a power-of-two FIFO, log2(depth).
package dfg_pkg;

    localparam int unsigned DfgTokenW = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } sink_state_e;

    // Address bits needed to index a FIFO of the given depth; the FIFO adds
    // one extra wrap bit on top of this to tell full from empty.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/dfg_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//
// A word pushed at edge k is visible on head/!empty right after edge k.
// head is registered and holds its last value while the FIFO is empty.
// A push into a full FIFO succeeds only when a pop happens on the same edge.
//
// Ports:
//   clk    clock
//   rst    asynchronous active-high reset, empties the FIFO, head=0
//   push   write din (ignored when full without a simultaneous pop)
//   din    write data
//   pop    remove the head word (ignored when empty)
//   head   head-of-queue data, valid while !empty
//   full   all DEPTH entries occupied
//   empty  no entries occupied
module dfg_sync_fifo
    import dfg_pkg::*;
#(
    parameter int unsigned N     = DfgTokenW,
    parameter int unsigned DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [N-1:0] din,
    input  logic         pop,
    output logic [N-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = ptr_w(DEPTH);

    logic [N-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  wr_ptr_nxt;
    logic [AW:0]  rd_ptr_nxt;
    logic         push_ok;
    logic         pop_ok;
    logic [N-1:0] next_head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign pop_ok  = pop && !empty;
    // When full, the slot being written is the one being popped this edge.
    assign push_ok = push && (!full || pop_ok);

    assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push_ok};
    assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop_ok};

    // Head after this edge: the slot rd_ptr_nxt points to, bypassing the
    // memory when that slot is being written right now.
    always_comb begin
        next_head = mem[rd_ptr_nxt[AW-1:0]];
        if (push_ok && (wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0])) begin
            next_head = din;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head   <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            if (wr_ptr_nxt != rd_ptr_nxt) begin
                head <= next_head;
            end
        end
    end

endmodule

// File: rtl/dfg_stream_sink.sv
// Terminal consumer of the dataflow operator chain.
//
// Captures tokens from the last operator (R_IN/D_IN) into a FIFO while a run
// is armed, counts them against a host-programmed total, drains them to the
// host over DOUT_VALID/DOUT_READY and reports completion. The operator side
// has no backpressure, so tokens arriving into a full FIFO are dropped and
// flagged on the sticky OVERFLOW output; they are still counted so a run
// always terminates.
//
// Ports:
//   CLK, RST    clock, asynchronous active-high reset
//   EN          global operator enable; capture only while high
//   R_IN, D_IN  token-present flag and token data from upstream
//   START       one-cycle pulse arming a run (honoured in IDLE/DONE only)
//   EXPECTED    token total of the run, sampled on START
//   DOUT        FIFO head data, valid while DOUT_VALID
//   DOUT_VALID  FIFO not empty
//   DOUT_READY  host accepts DOUT
//   COUNT       tokens received this run, dropped ones included
//   BUSY        run in progress (RUN or DRAIN)
//   DONE        run finished and FIFO drained
//   OVERFLOW    sticky: a token was dropped this run
module dfg_stream_sink
    import dfg_pkg::*;
#(
    parameter int unsigned N     = DfgTokenW,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             R_IN,
    input  logic [N-1:0]     D_IN,
    input  logic             START,
    input  logic [CNT_W-1:0] EXPECTED,
    output logic [N-1:0]     DOUT,
    output logic             DOUT_VALID,
    input  logic             DOUT_READY,
    output logic [CNT_W-1:0] COUNT,
    output logic             BUSY,
    output logic             DONE,
    output logic             OVERFLOW
);

    sink_state_e      state_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] exp_q;
    logic             busy_q;
    logic             done_q;
    logic             ovf_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic             capture;
    logic             pop;
    logic             drop;
    logic [CNT_W-1:0] count_inc;

    // The count < expected term keeps COUNT saturated at the run total.
    assign capture   = (state_q == StRun) && EN && R_IN && (count_q < exp_q);
    assign pop       = !fifo_empty && DOUT_READY;
    assign drop      = capture && fifo_full && !pop;
    assign count_inc = count_q + {{(CNT_W-1){1'b0}}, 1'b1};

    dfg_sync_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (capture),
        .din   (D_IN),
        .pop   (DOUT_READY),
        .head  (DOUT),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            count_q <= '0;
            exp_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (START) begin
                        exp_q   <= EXPECTED;
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= (EXPECTED == '0) ? StDrain : StRun;
                    end
                end
                StRun: begin
                    if (capture) begin
                        count_q <= count_inc;
                        if (drop) begin
                            ovf_q <= 1'b1;
                        end
                        if (count_inc == exp_q) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (fifo_empty) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign DOUT_VALID = !fifo_empty;
    assign COUNT      = count_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign OVERFLOW   = ovf_q;

endmodule
